zion_rf_rd_channel_array: RTL
=============================

Name: zion_rf_rd_channel_array

Overview:
- Parametrised integer register file with NUM_RD independent read channels and NUM_WR write ports.
- Each read channel carries an rs/dat pair, as the existing RfRdChannel, plus a request valid, a registered 1-cycle read, write-to-read bypass, a per-channel stall/hold and a returned-data valid.
- Sits between decode/issue (read side) and writeback (write side) of the processor pipeline.

Parameters:
- RV64, 0: XLEN = 32*(1+RV64).
- ADDR_W, 5: register index width; register count = 2**ADDR_W (4 gives RV32E, 16 regs).
- NUM_RD, 2: read channels, 1..4.
- NUM_WR, 1: write ports, 1..2; the higher index wins on a same-register conflict.
- ZERO_REG, 1: 1 = register 0 is hardwired zero (writes to it ignored).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_vld  input  NUM_RD  per-channel read request.
- rd_rs  input  NUM_RD*ADDR_W  per-channel source index; channel i at [i*ADDR_W +: ADDR_W].
- rd_stall  input  NUM_RD  per-channel hold of the output register.
- rd_dat  output  NUM_RD*XLEN  per-channel read data; channel i at [i*XLEN +: XLEN].
- rd_dat_vld  output  NUM_RD  rd_dat of that channel is valid.
- wr_en  input  NUM_WR  write enable per port.
- wr_rd  input  NUM_WR*ADDR_W  write destination index.
- wr_dat  input  NUM_WR*XLEN  write data.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - All 2**ADDR_W registers cleared to 0.
  - rd_dat all 0; rd_dat_vld all 0.
  - Reset wins over any same-cycle write or read. A read issued in the reset cycle is dropped (vld 0 the next cycle).
- Write: on the edge with wr_en[p]=1, reg[wr_rd[p]] <= wr_dat[p].
  - ZERO_REG=1 and wr_rd=0: ignored.
  - Two ports writing the same index in one cycle: port NUM_WR-1 value stored.
- Read latency: 1 cycle. rd_vld[i]=1 with rd_stall[i]=0 at edge N gives rd_dat[i]/rd_dat_vld[i]=1 after edge N.
- Bypass: a write accepted in the same cycle as a read to the same index returns the new wr_dat.
  - Port priority is as for writes.
  - No bypass to register 0 when ZERO_REG=1; it returns 0.
- Read of register 0 with ZERO_REG=1 always returns 0, including after any attempted write.
- Stall, rd_stall[i]=1:
  - rd_dat[i] and rd_dat_vld[i] hold their current values.
  - The request on rd_vld[i] is not captured; the requester must hold rd_vld/rd_rs until stall drops.
  - Held data is NOT refreshed by later writes. The consumer owns the hazard.
- rd_vld[i]=0 with no stall: rd_dat_vld[i] <= 0 next cycle; rd_dat[i] keeps its last value (no clearing).
- Channels are fully independent. All channels may read the same index in one cycle; each gets identical data.
- Index arithmetic: an index is always < 2**ADDR_W, so there is no out-of-range case. No X propagation from unwritten registers, since reset clears them.
- Reset mid-stall: outputs clear regardless of rd_stall.

Test Plan:
- Reset, then read x5 on ch0 and ch1 -> both rd_dat=0, rd_dat_vld=1 one cycle later; before reset deassert, rd_dat_vld=0.
- Write x3=0xDEADBEEF at cycle 1, read x3 ch0 at cycle 2 -> rd_dat[0]=0xDEADBEEF at cycle 3. Same test with RV64=1 writing 0x0123_4567_89AB_CDEF -> full 64-bit returned.
- Same-cycle write x7=0x55 and read x7 on ch1 -> rd_dat[1]=0x55 next cycle (bypass). NUM_WR=2: both ports write x7 (0x11 on port 0, 0x22 on port 1) -> read and stored value = 0x22.
- ZERO_REG=1: write x0=0xFFFF_FFFF (plain and same-cycle with a read) -> all reads of x0 return 0. ZERO_REG=0: same write -> returns 0xFFFF_FFFF.
- ch0 returns 0xA. Assert rd_stall[0] for 3 cycles while writing x1=0xB and presenting read x1 -> rd_dat[0] stays 0xA, vld stays 1. On stall release -> 0xB one cycle later. ch1 is unaffected throughout.
- Assert rst during active reads with stall high -> next cycle every rd_dat=0, rd_dat_vld=0; all registers read 0 afterwards.

Source files
------------

// File: rtl/zion_rf_rd_channel_array.sv
// Integer register file with NUM_RD registered read channels (1-cycle latency,
// write-to-read bypass, per-channel stall hold) and NUM_WR prioritised write ports.
module zion_rf_rd_channel_array #(
    parameter int RV64     = 0,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    localparam int XLEN    = 32 * (1 + RV64)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_vld,
    input  logic [NUM_RD*ADDR_W-1:0] rd_rs,
    input  logic [NUM_RD-1:0]        rd_stall,
    output logic [NUM_RD*XLEN-1:0]   rd_dat,
    output logic [NUM_RD-1:0]        rd_dat_vld,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_rd,
    input  logic [NUM_WR*XLEN-1:0]   wr_dat
);

    localparam int  NUM_REGS  = 2 ** ADDR_W;
    localparam bit  HARD_ZERO = (ZERO_REG != 0);

    logic [XLEN-1:0]   regs [NUM_REGS];
    logic [ADDR_W-1:0] wr_idx [NUM_WR];
    logic [XLEN-1:0]   wr_val [NUM_WR];
    logic [NUM_WR-1:0] wr_ok;

    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        assign wr_idx[p] = wr_rd[p*ADDR_W +: ADDR_W];
        assign wr_val[p] = wr_dat[p*XLEN +: XLEN];
        // Writes to the hardwired zero register are dropped entirely.
        assign wr_ok[p]  = wr_en[p] && !(HARD_ZERO && (wr_idx[p] == '0));
    end

    // Higher port index is applied last, so it wins on a same-index conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_ok[p]) begin
                    regs[wr_idx[p]] <= wr_val[p];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] rs;
        logic [XLEN-1:0]   rd_next;
        logic [XLEN-1:0]   dat_q;
        logic              vld_q;

        assign rs = rd_rs[i*ADDR_W +: ADDR_W];

        // Bypass follows the same port priority as the write itself.
        always_comb begin
            rd_next = regs[rs];
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_ok[p] && (wr_idx[p] == rs)) begin
                    rd_next = wr_val[p];
                end
            end
            if (HARD_ZERO && (rs == '0)) begin
                rd_next = '0;
            end
        end

        // Stalled data is deliberately not refreshed by later writes.
        always_ff @(posedge clk) begin
            if (rst) begin
                dat_q <= '0;
                vld_q <= 1'b0;
            end else if (!rd_stall[i]) begin
                vld_q <= rd_vld[i];
                if (rd_vld[i]) begin
                    dat_q <= rd_next;
                end
            end
        end

        assign rd_dat[i*XLEN +: XLEN] = dat_q;
        assign rd_dat_vld[i]          = vld_q;
    end

endmodule
